// File: rtl/mem_region_router_pkg.sv
// Shared configuration types for the memory region router: region
// descriptors, routing tags and the address-match helper.
package mem_region_router_pkg;

    // Largest supported number of downstream regions.
    localparam int MAX_REGIONS  = 8;
    localparam int REGION_IDX_W = $clog2(MAX_REGIONS);
    // Width of the routing tag: region index plus unmapped flag.
    localparam int TAG_W        = REGION_IDX_W + 1;
    // Descriptor addresses are held wide so any ADDR_W up to 64 fits.
    localparam int DESC_ADDR_W  = 64;

    // One region: it matches every address whose bits at and above
    // bit_check equal the same bits of base.
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] base;
        logic [7:0]             bit_check;
    } region_desc_t;

    // Remembered per accepted request so its response can be routed back.
    typedef struct packed {
        logic                    unmapped;
        logic [REGION_IDX_W-1:0] region;
    } route_tag_t;

    // True when addr falls inside the region described by desc.
    function automatic logic region_hit(input logic [DESC_ADDR_W-1:0] addr,
                                        input region_desc_t           desc);
        logic [DESC_ADDR_W-1:0] mask;
        mask = ~((DESC_ADDR_W'(1) << desc.bit_check) - DESC_ADDR_W'(1));
        return ((addr ^ desc.base) & mask) == '0;
    endfunction

endpackage

// File: rtl/router_tag_fifo.sv
// Small circular FIFO of routing tags. Pointers wrap modulo DEPTH
// (a power of two); count runs 0..DEPTH. A push while full is dropped.
module router_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic [TAG_W-1:0]       head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= tag_i;
    end

endmodule

// File: rtl/mem_region_router.sv
// Routes upstream memory requests to one of NUM_REGIONS targets by
// address and returns their responses upstream in request order.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; a source holds valid and its payload until that edge,
// and ready may depend combinationally on valid and payload.
module mem_region_router
    import mem_region_router_pkg::*;
#(
    parameter int NUM_REGIONS     = 3,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE =
        {32'h00030000, 32'h00020000, 32'h00020000},
    parameter logic [NUM_REGIONS-1:0][7:0] REGION_BIT_CHECK =
        {8'd16, 8'd15, 8'd16}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_we,
    input  logic [DATA_W/8-1:0]           req_be,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic [NUM_REGIONS-1:0]        tgt_valid,
    input  logic [NUM_REGIONS-1:0]        tgt_ready,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic                          tgt_we,
    output logic [DATA_W/8-1:0]           tgt_be,
    output logic [DATA_W-1:0]             tgt_wdata,
    input  logic [NUM_REGIONS-1:0]        tgt_rsp_valid,
    output logic [NUM_REGIONS-1:0]        tgt_rsp_ack,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rsp_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

    region_desc_t            desc [NUM_REGIONS];
    logic [REGION_IDX_W-1:0] winner;
    logic                    mapped;
    logic                    win_ready;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    route_tag_t              push_tag, head_tag;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_desc
        assign desc[g].base      = DESC_ADDR_W'(REGION_BASE[g]);
        assign desc[g].bit_check = REGION_BIT_CHECK[g];
    end

    // Request fields are broadcast; only the selected target sees valid.
    assign tgt_addr  = req_addr;
    assign tgt_we    = req_we;
    assign tgt_be    = req_be;
    assign tgt_wdata = req_wdata;

    // Address decode; scanning downward leaves the lowest matching index.
    always_comb begin
        winner = '0;
        mapped = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_hit(DESC_ADDR_W'(req_addr), desc[i])) begin
                winner = REGION_IDX_W'(i);
                mapped = 1'b1;
            end
        end
    end

    // Ready of the selected target; unmapped requests never wait on one.
    always_comb begin
        win_ready = 1'b1;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (mapped && winner == REGION_IDX_W'(i)) win_ready = tgt_ready[i];
        end
    end

    // Per-target valid; a full tag FIFO blocks new requests even if a
    // response retires in the same cycle.
    always_comb begin
        tgt_valid = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            tgt_valid[i] = !rst && req_valid && !fifo_full && mapped &&
                           (winner == REGION_IDX_W'(i));
        end
    end

    assign req_ready = !rst && !fifo_full && win_ready;
    assign push      = req_valid && req_ready;
    assign push_tag  = '{unmapped: !mapped, region: winner};

    router_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .tag_i   (push_tag),
        .head_o  (head_tag),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (outstanding)
    );

    // Response path follows the oldest tag only; other regions' responses
    // stay pending (unacked) until their tag reaches the head.
    always_comb begin
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        tgt_rsp_ack = '0;
        if (!rst && !fifo_empty) begin
            if (head_tag.unmapped) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (head_tag.region == REGION_IDX_W'(i)) begin
                        rsp_valid = tgt_rsp_valid[i];
                        rsp_rdata = tgt_rsp_rdata[i*DATA_W +: DATA_W];
                    end
                end
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    tgt_rsp_ack[i] = (head_tag.region == REGION_IDX_W'(i)) &&
                                     rsp_valid && rsp_ready;
                end
            end
        end
    end

    assign pop = rsp_valid && rsp_ready;

endmodule

// File: tb/tb_mem_region_router.sv
// Self-checking bench for mem_region_router: directed scenarios plus a
// randomized phase, scored against a queue-based reference model.
module tb_mem_region_router;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam logic [NR-1:0][AW-1:0] BASE_P = {32'h00030000, 32'h00020000, 32'h00020000};
    localparam logic [NR-1:0][7:0]    BITS_P = {8'd16, 8'd15, 8'd16};

    // Region map as plain numbers for the reference decode (index 0 first).
    int unsigned base_u [NR] = '{32'h00020000, 32'h00020000, 32'h00030000};
    int          bits_u [NR] = '{16, 15, 16};

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [AW-1:0]    req_addr;
    logic             req_we;
    logic [DW/8-1:0]  req_be;
    logic [DW-1:0]    req_wdata;
    logic [NR-1:0]    tgt_valid, tgt_ready;
    logic [AW-1:0]    tgt_addr;
    logic             tgt_we;
    logic [DW/8-1:0]  tgt_be;
    logic [DW-1:0]    tgt_wdata;
    logic [NR-1:0]    tgt_rsp_valid, tgt_rsp_ack;
    logic [NR*DW-1:0] tgt_rsp_rdata;
    logic             rsp_valid, rsp_ready;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [2:0]       outstanding;

    int errors = 0;
    int checks = 0;

    // Scoreboard: one entry per accepted request {err, region[2:0], data}.
    logic [35:0] exp_q[$];
    // Target models: per-region ring of data still to be returned.
    logic [DW-1:0] tq_mem [NR][16];
    int            tq_head [NR];
    int            tq_cnt  [NR];
    bit            held    [NR];
    bit            rsp_allow [NR];
    int            allow_pct;
    logic [DW-1:0] next_data;
    bit            req_accepted;

    mem_region_router #(
        .NUM_REGIONS      (NR),
        .ADDR_W           (AW),
        .DATA_W           (DW),
        .MAX_OUTSTANDING  (MO),
        .REGION_BASE      (BASE_P),
        .REGION_BIT_CHECK (BITS_P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_we        (req_we),
        .req_be        (req_be),
        .req_wdata     (req_wdata),
        .tgt_valid     (tgt_valid),
        .tgt_ready     (tgt_ready),
        .tgt_addr      (tgt_addr),
        .tgt_we        (tgt_we),
        .tgt_be        (tgt_be),
        .tgt_wdata     (tgt_wdata),
        .tgt_rsp_valid (tgt_rsp_valid),
        .tgt_rsp_ack   (tgt_rsp_ack),
        .tgt_rsp_rdata (tgt_rsp_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .outstanding   (outstanding)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode: first region whose high address bits equal its base.
    function automatic int model_region(input logic [31:0] a);
        for (int i = 0; i < NR; i++) begin
            if ((a >> bits_u[i]) == (base_u[i] >> bits_u[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h00020000 | 32'($urandom_range(0, 16'hFFFF));
            1:       return 32'h00030000 | 32'($urandom_range(0, 16'hFFFF));
            2:       return 32'h00028000 | 32'($urandom_range(0, 16'h7FFF));
            default: return $urandom;
        endcase
    endfunction

    // Target response driver: once a region raises rsp_valid it holds it.
    task automatic drive_regions();
        for (int i = 0; i < NR; i++) begin
            if (tq_cnt[i] > 0 && !held[i] && rsp_allow[i] &&
                $urandom_range(1, 100) <= allow_pct) held[i] = 1'b1;
            tgt_rsp_valid[i] = held[i];
            tgt_rsp_rdata[i*DW +: DW] = held[i] ? tq_mem[i][tq_head[i]] : $urandom;
        end
    endtask

    // One clock: drive targets, score outputs, advance model at the edge.
    task automatic run_cycle();
        int            r, hr;
        logic          exp_ready, exp_v, exp_err, rsp_fire, req_fire;
        logic [NR-1:0] exp_tv, exp_ack;
        logic [DW-1:0] exp_data;
        logic [35:0]   h;
        req_accepted = 1'b0;
        drive_regions();
        #1;
        r = model_region(req_addr);
        exp_ready = !rst && (exp_q.size() < MO);
        if (r >= 0) exp_ready = exp_ready && tgt_ready[r];
        exp_tv = '0;
        if (!rst && req_valid && exp_q.size() < MO && r >= 0) exp_tv[r] = 1'b1;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b (addr %h)", req_ready, exp_ready, req_addr);
        end
        checks++;
        if (tgt_valid !== exp_tv) begin
            errors++;
            $display("FAIL tgt_valid: got %b expected %b (addr %h)", tgt_valid, exp_tv, req_addr);
        end
        checks++;
        if ({tgt_addr, tgt_we, tgt_be, tgt_wdata} !== {req_addr, req_we, req_be, req_wdata}) begin
            errors++;
            $display("FAIL tgt_fields: got %h/%b/%h/%h expected %h/%b/%h/%h", tgt_addr, tgt_we,
                     tgt_be, tgt_wdata, req_addr, req_we, req_be, req_wdata);
        end
        rsp_fire = 1'b0;
        if (!rst) begin
            exp_v = 1'b0; exp_err = 1'b0; exp_data = '0; exp_ack = '0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                hr = int'(h[34:32]);
                if (h[35]) begin
                    exp_v = 1'b1; exp_err = 1'b1;
                end else begin
                    exp_v = held[hr];
                    exp_data = h[31:0];
                    if (exp_v && rsp_ready) exp_ack[hr] = 1'b1;
                end
            end
            checks++;
            if (outstanding !== 3'(exp_q.size())) begin
                errors++;
                $display("FAIL outstanding: got %0d expected %0d", outstanding, exp_q.size());
            end
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_v);
            end
            if (exp_v || exp_q.size() == 0) begin
                checks++;
                if (rsp_rdata !== exp_data || rsp_err !== exp_err) begin
                    errors++;
                    $display("FAIL rsp_payload: got %h err %b expected %h err %b", rsp_rdata,
                             rsp_err, exp_data, exp_err);
                end
            end
            checks++;
            if (tgt_rsp_ack !== exp_ack) begin
                errors++;
                $display("FAIL tgt_rsp_ack: got %b expected %b", tgt_rsp_ack, exp_ack);
            end
            rsp_fire = exp_v && rsp_ready;
        end
        req_fire = req_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < NR; i++) begin
                tq_cnt[i] = 0; tq_head[i] = 0; held[i] = 1'b0;
            end
        end else begin
            if (rsp_fire) begin
                h = exp_q.pop_front();
                if (!h[35]) begin
                    hr = int'(h[34:32]);
                    tq_head[hr] = (tq_head[hr] + 1) % 16;
                    tq_cnt[hr]--;
                    held[hr] = 1'b0;
                end
            end
            if (req_fire) begin
                req_accepted = 1'b1;
                if (r >= 0) begin
                    exp_q.push_back({1'b0, 3'(r), next_data});
                    tq_mem[r][(tq_head[r] + tq_cnt[r]) % 16] = next_data;
                    tq_cnt[r]++;
                end else begin
                    exp_q.push_back({1'b1, 3'd0, 32'd0});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_allow(input bit a0, input bit a1, input bit a2, input int pct);
        rsp_allow[0] = a0; rsp_allow[1] = a1; rsp_allow[2] = a2; allow_pct = pct;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic we, input logic [31:0] data);
        req_valid = 1'b1; req_addr = addr; req_we = we;
        req_be = 4'($urandom_range(0, 15)); req_wdata = $urandom; next_data = data;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] data);
        int n = 0;
        set_req(addr, we, data);
        do begin
            run_cycle();
            n++;
        end while (!req_accepted && n < 50);
        req_valid = 1'b0;
        checks++;
        if (!req_accepted) begin
            errors++;
            $display("FAIL issue_timeout: addr %h not accepted after %0d cycles (required accept)", addr, n);
        end
    endtask

    // Let every region answer until the scoreboard is empty (bounded).
    task automatic drain();
        int n = 0;
        req_valid = 1'b0; rsp_ready = 1'b1; tgt_ready = '1;
        set_allow(1, 1, 1, 100);
        while (exp_q.size() > 0 && n < 200) begin
            run_cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tgt_ready = '1; rsp_ready = 1'b1;
        set_allow(0, 0, 0, 0);
        set_req(32'h00020010, 1'b0, 32'h0);
        run_cycle();
        run_cycle();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b required 0", req_ready);
        end
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (outstanding !== 3'd0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            tgt_valid !== '0 || tgt_rsp_ack !== '0) begin
            errors++;
            $display("FAIL reset_state: outst %0d rsp_valid %b rsp_err %b tgt_valid %b ack %b, required all 0",
                     outstanding, rsp_valid, rsp_err, tgt_valid, tgt_rsp_ack);
        end
        run_cycle();
    endtask

    task automatic test_decode();
        set_allow(0, 0, 0, 0); rsp_ready = 1'b1;
        set_req(32'h00020010, 1'b0, 32'hDEADBEEF);
        #1;
        checks++;
        if (tgt_valid !== 3'b001) begin
            errors++;
            $display("FAIL decode_priority: tgt_valid %b required 001", tgt_valid);
        end
        issue(32'h00020010, 1'b0, 32'hDEADBEEF);
        drain();
        set_req(32'h00031000, 1'b0, 32'h12345678);
        #1;
        checks++;
        if (tgt_valid !== 3'b100) begin
            errors++;
            $display("FAIL decode_region2: tgt_valid %b required 100", tgt_valid);
        end
        issue(32'h00031000, 1'b0, 32'h12345678);
        drain();
        rsp_ready = 1'b0;
        set_req(32'h10000000, 1'b0, 32'h0);
        #1;
        checks++;
        if (tgt_valid !== 3'b000 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL decode_unmapped: tgt_valid %b req_ready %b required 000 1", tgt_valid, req_ready);
        end
        issue(32'h10000000, 1'b0, 32'h0);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0 || tgt_rsp_ack !== '0) begin
            errors++;
            $display("FAIL unmapped_rsp: valid %b err %b data %h ack %b required 1 1 0 000",
                     rsp_valid, rsp_err, rsp_rdata, tgt_rsp_ack);
        end
        drain();
    endtask

    task automatic test_ordering();
        set_allow(0, 0, 0, 0); rsp_ready = 1'b1;
        issue(32'h00031000, 1'b0, 32'hAAAA0001);
        issue(32'h00020010, 1'b1, 32'hBBBB0002);
        set_allow(1, 0, 0, 100);
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            checks++;
            if (tgt_rsp_ack !== '0 || outstanding !== 3'd2) begin
                errors++;
                $display("FAIL order_hold: ack %b outst %0d required 000 2", tgt_rsp_ack, outstanding);
            end
        end
        drain();
    endtask

    task automatic test_full();
        set_allow(0, 0, 0, 0); rsp_ready = 1'b1;
        issue(32'h00030040, 1'b0, 32'h0000A001);
        issue(32'h00020080, 1'b1, 32'h0000A002);
        issue(32'h10002000, 1'b0, 32'h0);
        issue(32'h00031234, 1'b0, 32'h0000A004);
        set_req(32'h00020100, 1'b0, 32'h0000A005);
        #1;
        checks++;
        if (outstanding !== 3'd4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: outst %0d req_ready %b required 4 0", outstanding, req_ready);
        end
        set_allow(0, 0, 1, 100);
        run_cycle();
        checks++;
        if (req_accepted || outstanding !== 3'd3) begin
            errors++;
            $display("FAIL full_pop_push: accepted %b outst %0d required 0 3", req_accepted, outstanding);
        end
        set_allow(0, 0, 0, 0);
        run_cycle();
        checks++;
        if (!req_accepted || outstanding !== 3'd4) begin
            errors++;
            $display("FAIL full_retry: accepted %b outst %0d required 1 4", req_accepted, outstanding);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_allow(0, 0, 0, 0); rsp_ready = 1'b1;
        issue(32'h00020010, 1'b0, 32'h0000C001);
        issue(32'h00030010, 1'b0, 32'h0000C002);
        issue(32'h00020020, 1'b1, 32'h0000C003);
        checks++;
        if (outstanding !== 3'd3) begin
            errors++;
            $display("FAIL mid_fill: outst %0d required 3", outstanding);
        end
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (outstanding !== 3'd0 || rsp_valid !== 1'b0 || tgt_rsp_ack !== '0) begin
            errors++;
            $display("FAIL mid_reset: outst %0d rsp_valid %b ack %b required 0 0 000",
                     outstanding, rsp_valid, tgt_rsp_ack);
        end
        issue(32'h00020044, 1'b0, 32'h0000C004);
        drain();
    endtask

    task automatic test_back_to_back();
        int max_out = 0;
        tgt_ready = '1; rsp_ready = 1'b1;
        set_allow(1, 1, 1, 100);
        req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!req_valid) set_req(rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            run_cycle();
            if (req_accepted) req_valid = 1'b0;
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
        end
        for (int c = 0; c < 200; c++) begin
            tgt_ready = 3'($urandom_range(0, 7));
            rsp_ready = 1'($urandom_range(0, 1));
            allow_pct = 40;
            if (!req_valid && $urandom_range(1, 100) <= 70)
                set_req(rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            run_cycle();
            if (req_accepted) req_valid = 1'b0;
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
        end
        checks++;
        if (max_out > MO) begin
            errors++;
            $display("FAIL outstanding_bound: max %0d required <= %0d", max_out, MO);
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            tq_cnt[i] = 0; tq_head[i] = 0; held[i] = 1'b0;
        end
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = '0;
        req_wdata = '0; tgt_ready = '0; tgt_rsp_valid = '0; tgt_rsp_rdata = '0;
        rsp_ready = 1'b0; next_data = '0; allow_pct = 0;
        test_reset();
        test_decode();
        test_ordering();
        test_full();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_region_router.md
MEM_REGION_ROUTER -- requirements
Module: mem_region_router

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 3, number of downstream memory sources (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, outstanding-request depth (power of 2, 2..16).
REQ-005 SHALL have parameter REGION_BASE, default {32'h00030000, 32'h00020000, 32'h00020000}, base address per region (index 0 rightmost).
REQ-006 SHALL have parameter REGION_BIT_CHECK, default {16, 15, 16}, lowest compared address bit per region.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 req_valid/req_ready  in/out  1/1  upstream request handshake.
REQ-010 req_addr, req_we, req_be, req_wdata  in  ADDR_W, 1, DATA_W/8, DATA_W  upstream request fields.
REQ-011 tgt_valid/tgt_ready  out/in  NUM_REGIONS each  per-region request handshake.
REQ-012 tgt_addr, tgt_we, tgt_be, tgt_wdata  out  shared, same widths as upstream  broadcast request fields.
REQ-013 tgt_rsp_valid/tgt_rsp_ack  in/out  NUM_REGIONS each  per-region response handshake; a region holds rsp_valid and data until acked.
REQ-014 tgt_rsp_rdata  in  NUM_REGIONS*DATA_W  per-region read data, flattened.
REQ-015 rsp_valid/rsp_ready  out/in  1/1  upstream response handshake.
REQ-016 rsp_rdata, rsp_err  out  DATA_W, 1  upstream response data and unmapped-address flag.
REQ-017 outstanding  out  $clog2(MAX_OUTSTANDING)+1  count of accepted, unretired requests.

Function
REQ-018 Region i SHALL match when req_addr[ADDR_W-1:REGION_BIT_CHECK[i]] equals REGION_BASE[i] in the same bits.
REQ-019 On multiple matches the lowest index SHALL win; no match means unmapped.
REQ-020 tgt_valid[i] SHALL equal req_valid AND winner==i AND tag FIFO not full; tgt_* fields SHALL be combinational copies of req_*.
REQ-021 req_ready SHALL equal (not full) AND (tgt_ready[winner] for a mapped request, or 1 for unmapped).
REQ-022 Each accepted request, read or write, SHALL push one tag {region index, unmapped flag} into the tag FIFO; every request yields exactly one response.
REQ-023 Full FIFO SHALL block acceptance even when a pop occurs in the same cycle.
REQ-024 Responses SHALL return in request order: only the head tag's region SHALL be forwarded; responses from other regions SHALL wait (unacked).
REQ-025 Mapped head: rsp_valid = tgt_rsp_valid[head]; rsp_rdata = that region's data; rsp_err = 0; tgt_rsp_ack[head] = rsp_valid AND rsp_ready; all other acks 0.
REQ-026 Unmapped head: rsp_valid = 1, rsp_rdata = 0, rsp_err = 1, no region acked; retires on rsp_ready.
REQ-027 Pop SHALL occur on rsp_valid AND rsp_ready; push and pop in the same cycle SHALL leave outstanding unchanged.
REQ-028 Request path and response path SHALL both be zero-latency (combinational); only the tag FIFO and count are registered.
REQ-029 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING; outstanding SHALL range 0..MAX_OUTSTANDING.
REQ-030 Empty FIFO: rsp_valid = 0, all tgt_rsp_ack = 0, rsp_rdata = 0, rsp_err = 0.

Reset
REQ-031 On rst: read/write pointers and outstanding SHALL be 0; rsp_valid, rsp_err, all tgt_valid and tgt_rsp_ack SHALL be 0 in the cycle after reset.
REQ-032 Reset mid-operation SHALL discard all outstanding tags; late region responses after reset are the system's responsibility and SHALL NOT be acked until new requests are issued to that region.
REQ-033 While rst is high, req_ready SHALL be 0.

Structure
REQ-034 The region descriptor typedef (base, bit_check) and the max-region constant SHALL live in a shared package, so core configuration derives router parameters from it.
REQ-035 The tag FIFO SHALL be one sub-module, router_tag_fifo, parametrised by depth and tag width.

Verification
REQ-036 Read to 0x00020010 (defaults) -> region 0 tgt_valid; region 1 also matches but loses priority; response data 0xDEADBEEF returned, rsp_err=0.
REQ-037 Read to 0x00031000 -> region 2; read to 0x10000000 -> rsp_err=1, rsp_rdata=0, no tgt_valid asserted.
REQ-038 Issue A to region 2, then B to region 0; region 0 responds first -> B held unacked until A returns; upstream order A, B.
REQ-039 Issue 4 requests with no responses -> outstanding=4, req_ready=0; one response plus new request in the same cycle -> request still stalled; next cycle accepted.
REQ-040 Assert rst with 3 outstanding -> next cycle outstanding=0, rsp_valid=0; new request accepted normally.
REQ-041 Back-to-back push/pop for 20 cycles across all regions -> wrap-around correct, outstanding never exceeds 4, no lost or duplicated responses.
